add_rs_unit: RTL
================

Name: add_rs_unit

Overview:
- Parametrised adder reservation-station bank plus single-issue integer adder/compare unit for the Tomasulo core.
- Holds up to DEPTH pending ADD/SUB/JEQ ops and captures operands from the load bus and its own result bus.
- Issues the oldest ready entry into a registered result stage and broadcasts results with valid/ready flow control.
- Sits between the dispatch stage and the common result arbiter.

Parameters:
- DEPTH, 4, number of station entries (2..8).
- DW, 16, operand/result data width.
- TW, 4, tag width; tag all-ones (TAG_NONE) means "no producer".
- RW, 4, architectural register index width.
- TAG_BASE, 0, tag of entry 0; entry i owns tag TAG_BASE+i. Legal only when TAG_BASE+DEPTH-1 < TAG_NONE.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  clear all entries and the result stage (mispredict)
- alloc_valid  in  1  dispatch offers an op
- alloc_ready  out  1  a free entry exists
- alloc_tag  out  TW  tag the offered op will receive (lowest free index)
- alloc_op  in  4  opcode: 1 ADD, 5 ADDI, 2 SUB, 6 JEQ
- alloc_dest  in  RW  destination register
- alloc_v0 / alloc_v1  in  DW  operand values
- alloc_rdy0 / alloc_rdy1  in  1  operand already valid
- alloc_src0 / alloc_src1  in  TW  producer tag when not ready
- load_valid  in  1  load bus broadcast
- load_data  in  DW  load bus value
- load_tag  in  TW  load bus producer tag
- res_valid  out  1  result stage holds a result
- res_ready  in  1  arbiter accepts result this cycle
- res_data  out  DW  sum/difference; for JEQ, equals res_dest zero-extended
- res_tag  out  TW  producing entry tag
- res_dest  out  RW  destination register
- res_is_jeq  out  1  result is a JEQ
- res_jeq_taken  out  1  JEQ operands were equal
- occupancy  out  clog2(DEPTH)+1  busy entry count

Behaviour:
- Reset and flush, next edge: all entries not busy; result stage empty. Outputs become res_valid=0, res_data/res_tag/res_dest/res_is_jeq/res_jeq_taken=0, occupancy=0, alloc_ready=1, alloc_tag=TAG_BASE. Reset has priority over flush; flush has priority over every other event in the same cycle.
- Allocation: on alloc_valid && alloc_ready, the lowest-index free entry loads the op and becomes busy.
  - A not-ready operand keeps its src tag.
  - A ready operand stores TAG_NONE as its src.
- Capture:
  - Each cycle, every busy, not-ready operand whose src equals load_tag (when load_valid) takes load_data.
  - Likewise it takes res_data when its src equals res_tag (when res_valid && res_ready).
  - On capture: ready=1, src=TAG_NONE.
- Allocation bypass: an operand arriving with alloc_rdy=0 whose src matches a same-cycle broadcast is written already ready with the broadcast value.
- Load/result tag collision: if load and result broadcasts carry the same tag in one cycle, the result bus wins.
- Age: an N×N age matrix records allocation order. Among busy entries with both operands ready, the oldest is selected.
- Issue: allowed when the result stage is empty or being drained this cycle (res_ready). The selected entry is freed on issue. Its result is registered; res_valid rises the next cycle, so ready-to-visible latency is 1.
- Width rules: ADD/ADDI = v0+v1 mod 2^DW; SUB = v0-v1 mod 2^DW; JEQ sets res_jeq_taken = (v0==v1).
- Undefined opcode: treated as ADD.
- Backpressure: while res_valid && !res_ready, all res_* outputs hold stable and no issue occurs. Entries keep capturing.
- Full: alloc_ready=0; alloc_valid is ignored with no state change.
- Same-cycle free and allocate: the freed entry is not reusable until the next cycle, so alloc_ready reflects start-of-cycle state.
- Occupancy = busy count, updated registered.
- An entry never captures its own tag.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD, OP_ADDI, OP_SUB, OP_JEQ;
  - TAG_NONE;
  - the entry struct (busy, op, dest, v0, rdy0, src0, v1, rdy1, src1).
- One sub-module, add_rs_age_matrix: tracks order; inputs alloc one-hot, free one-hot, ready vector; output oldest-ready one-hot.

Test Plan:
- Dispatch ADD dest=3, v0=5, v1=7, both ready; res_ready=1 -> res_valid exactly 2 cycles after alloc with res_data=12, res_dest=3, res_tag=TAG_BASE.
- Dispatch SUB v0=2, v1=5, both ready, DW=16 -> res_data=0xFFFD.
- ADD with src0=9 not ready, then load_valid with load_tag=9, load_data=0x0100, v1=1 -> result 0x0101 one cycle after capture.
- Age ordering and dependency, DEPTH=4, res_ready=1:
  - Allocate entries A (tags 0..1 pending), B ready, C ready; free A by issuing it; allocate D into slot 0.
  - B and C issue before D; D depends on B's tag and captures B's result from the result bus.
- Hold res_ready=0 for 5 cycles with 4 ready ops -> first result stable, occupancy=3, alloc_ready=1. Then alloc_ready=0 after one more alloc.
- Assert flush with res_valid=1 -> next cycle res_valid=0, occupancy=0. JEQ v0=v1=4 afterwards -> res_is_jeq=1, res_jeq_taken=1.

Source files
------------

// File: rtl/add_rs_unit_pkg.sv
// Shared types and constants for the adder reservation-station unit.
// The entry and operand structs are sized by the core's standard widths.
// add_rs_unit keeps its DW/TW/RW parameters equal to these widths.
package add_rs_unit_pkg;

    localparam int RS_DW = 16;
    localparam int RS_TW = 4;
    localparam int RS_RW = 4;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_JEQ  = 4'd6;

    // All-ones tag: the operand has no outstanding producer.
    localparam logic [RS_TW-1:0] TAG_NONE = {RS_TW{1'b1}};

    typedef struct packed {
        logic             busy;
        logic [3:0]       op;
        logic [RS_RW-1:0] dest;
        logic [RS_DW-1:0] v0;
        logic             rdy0;
        logic [RS_TW-1:0] src0;
        logic [RS_DW-1:0] v1;
        logic             rdy1;
        logic [RS_TW-1:0] src1;
    } rs_entry_t;

    typedef struct packed {
        logic             rdy;
        logic [RS_TW-1:0] src;
        logic [RS_DW-1:0] val;
    } rs_operand_t;

    // Resolve one waiting operand against both broadcast buses.
    // The result bus wins a tag collision; an entry ignores its own tag.
    function automatic rs_operand_t snoop_operand(
        input rs_operand_t      cur,
        input logic [RS_TW-1:0] own_tag,
        input logic             rb_valid,
        input logic [RS_TW-1:0] rb_tag,
        input logic [RS_DW-1:0] rb_data,
        input logic             lb_valid,
        input logic [RS_TW-1:0] lb_tag,
        input logic [RS_DW-1:0] lb_data
    );
        rs_operand_t nxt;
        if (cur.rdy || (cur.src == own_tag)) begin
            nxt = cur;
        end else if (rb_valid && (cur.src == rb_tag)) begin
            nxt = '{rdy: 1'b1, src: TAG_NONE, val: rb_data};
        end else if (lb_valid && (cur.src == lb_tag)) begin
            nxt = '{rdy: 1'b1, src: TAG_NONE, val: lb_data};
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/add_rs_age_matrix.sv
// Allocation-order matrix: older_r[i][j] set means entry i was allocated
// before entry j. Picks the single oldest entry among the ready ones.
module add_rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] oldest
);

    logic [DEPTH-1:0] older_r [DEPTH];
    logic [DEPTH-1:0] older_n [DEPTH];

    // Next matrix: a new entry is younger than everyone; a freed entry drops all relations.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i == j) begin
                    older_n[i][j] = 1'b0;
                end else if (free[i] || free[j]) begin
                    older_n[i][j] = 1'b0;
                end else if (alloc[i]) begin
                    older_n[i][j] = 1'b0;
                end else if (alloc[j]) begin
                    older_n[i][j] = 1'b1;
                end else begin
                    older_n[i][j] = older_r[i][j];
                end
            end
        end
    end

    // Matrix state register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                older_r[i] <= older_n[i];
            end
        end
    end

    // A ready entry is oldest when no other ready entry is older than it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready[j] && older_r[j][i]) begin
                    oldest[i] = 1'b0;
                end else begin
                    oldest[i] = oldest[i];
                end
            end
        end
    end

endmodule

// File: rtl/add_rs_unit.sv
// Adder reservation-station bank with a single-issue ADD/SUB/JEQ unit.
// Entries snoop the load bus and the unit's own result bus, the oldest
// ready entry issues into a registered result stage with valid/ready.
module add_rs_unit
    import add_rs_unit_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  int DW       = RS_DW,
    parameter  int TW       = RS_TW,
    parameter  int RW       = RS_RW,
    parameter  int TAG_BASE = 0,
    localparam int OW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag,
    input  logic [3:0]    alloc_op,
    input  logic [RW-1:0] alloc_dest,
    input  logic [DW-1:0] alloc_v0,
    input  logic [DW-1:0] alloc_v1,
    input  logic          alloc_rdy0,
    input  logic          alloc_rdy1,
    input  logic [TW-1:0] alloc_src0,
    input  logic [TW-1:0] alloc_src1,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    input  logic [TW-1:0] load_tag,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [TW-1:0] res_tag,
    output logic [RW-1:0] res_dest,
    output logic          res_is_jeq,
    output logic          res_jeq_taken,
    output logic [OW-1:0] occupancy
);

    localparam int IW = $clog2(DEPTH);

    rs_entry_t        ent_r [DEPTH];
    rs_entry_t        ent_n [DEPTH];
    rs_entry_t        new_ent_s;
    rs_entry_t        sel_s;

    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] oldest_s;
    logic [DEPTH-1:0] alloc_oh_s;
    logic [DEPTH-1:0] free_oh_s;
    logic [IW-1:0]    free_idx_s;
    logic [IW-1:0]    issue_idx_s;
    logic             have_free_s;
    logic             alloc_fire_s;
    logic             issue_s;
    logic             rb_valid_s;
    logic [TW-1:0]    alloc_tag_s;

    logic             res_valid_r;
    logic [DW-1:0]    res_data_r;
    logic [TW-1:0]    res_tag_r;
    logic [RW-1:0]    res_dest_r;
    logic             res_is_jeq_r;
    logic             res_jeq_taken_r;
    logic [OW-1:0]    occupancy_r;

    logic [DW-1:0]    res_data_n;
    logic [TW-1:0]    res_tag_n;
    logic             res_is_jeq_n;
    logic             res_jeq_taken_n;
    logic [OW-1:0]    occ_n;

    // Lowest free slot and the per-entry ready vector, from start-of-cycle state.
    always_comb begin
        have_free_s = 1'b0;
        free_idx_s  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            have_free_s = have_free_s | ~ent_r[i].busy;
            free_idx_s  = ent_r[i].busy ? free_idx_s : IW'(i);
            ready_s[i]  = ent_r[i].busy & ent_r[i].rdy0 & ent_r[i].rdy1;
        end
    end

    // Handshake decode: allocation, issue permission and result-bus broadcast.
    always_comb begin
        alloc_fire_s = alloc_valid & have_free_s;
        alloc_oh_s   = alloc_fire_s ? (DEPTH'(1) << free_idx_s) : '0;
        issue_s      = (~res_valid_r | res_ready) & (|oldest_s);
        free_oh_s    = issue_s ? oldest_s : '0;
        rb_valid_s   = res_valid_r & res_ready;
        alloc_tag_s  = TW'(TAG_BASE) + TW'(free_idx_s);
        issue_idx_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_idx_s = issue_idx_s | (oldest_s[i] ? IW'(i) : '0);
        end
    end

    add_rs_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk    (clk),
        .reset  (reset),
        .clear  (flush),
        .alloc  (alloc_oh_s),
        .free   (free_oh_s),
        .ready  (ready_s),
        .oldest (oldest_s)
    );

    // Incoming op, with operands bypassed from same-cycle broadcasts.
    always_comb begin
        rs_operand_t a0;
        rs_operand_t a1;
        a0 = snoop_operand('{rdy: alloc_rdy0, src: (alloc_rdy0 ? TAG_NONE : alloc_src0), val: alloc_v0},
                           alloc_tag_s, rb_valid_s, res_tag_r, res_data_r, load_valid, load_tag, load_data);
        a1 = snoop_operand('{rdy: alloc_rdy1, src: (alloc_rdy1 ? TAG_NONE : alloc_src1), val: alloc_v1},
                           alloc_tag_s, rb_valid_s, res_tag_r, res_data_r, load_valid, load_tag, load_data);
        new_ent_s.busy = 1'b1;
        new_ent_s.op   = alloc_op;
        new_ent_s.dest = alloc_dest;
        new_ent_s.v0   = a0.val;
        new_ent_s.rdy0 = a0.rdy;
        new_ent_s.src0 = a0.src;
        new_ent_s.v1   = a1.val;
        new_ent_s.rdy1 = a1.rdy;
        new_ent_s.src1 = a1.src;
    end

    // Per-entry next state: allocate, free on issue, or capture broadcasts.
    always_comb begin
        rs_operand_t c0;
        rs_operand_t c1;
        for (int i = 0; i < DEPTH; i++) begin
            c0 = snoop_operand('{rdy: ent_r[i].rdy0, src: ent_r[i].src0, val: ent_r[i].v0},
                               TW'(TAG_BASE + i), rb_valid_s, res_tag_r, res_data_r,
                               load_valid, load_tag, load_data);
            c1 = snoop_operand('{rdy: ent_r[i].rdy1, src: ent_r[i].src1, val: ent_r[i].v1},
                               TW'(TAG_BASE + i), rb_valid_s, res_tag_r, res_data_r,
                               load_valid, load_tag, load_data);
            ent_n[i] = ent_r[i];
            if (alloc_oh_s[i]) begin
                ent_n[i] = new_ent_s;
            end else if (free_oh_s[i]) begin
                ent_n[i].busy = 1'b0;
            end else if (ent_r[i].busy) begin
                ent_n[i].v0   = c0.val;
                ent_n[i].rdy0 = c0.rdy;
                ent_n[i].src0 = c0.src;
                ent_n[i].v1   = c1.val;
                ent_n[i].rdy1 = c1.rdy;
                ent_n[i].src1 = c1.src;
            end else begin
                ent_n[i] = ent_r[i];
            end
        end
    end

    // Busy count of the next state, registered as occupancy.
    always_comb begin
        occ_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_n = occ_n + OW'(ent_n[i].busy);
        end
    end

    // Execute the selected entry: ADD/ADDI and undefined opcodes add.
    always_comb begin
        sel_s     = ent_r[issue_idx_s];
        res_tag_n = TW'(TAG_BASE) + TW'(issue_idx_s);
        case (sel_s.op)
            OP_SUB: begin
                res_data_n      = sel_s.v0 - sel_s.v1;
                res_is_jeq_n    = 1'b0;
                res_jeq_taken_n = 1'b0;
            end
            OP_JEQ: begin
                res_data_n      = DW'(sel_s.dest);
                res_is_jeq_n    = 1'b1;
                res_jeq_taken_n = (sel_s.v0 == sel_s.v1);
            end
            default: begin
                res_data_n      = sel_s.v0 + sel_s.v1;
                res_is_jeq_n    = 1'b0;
                res_jeq_taken_n = 1'b0;
            end
        endcase
    end

    // Station entries and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
            occupancy_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= ent_n[i];
            end
            occupancy_r <= occ_n;
        end
    end

    // Result stage: load on issue, empty when drained, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            res_valid_r     <= 1'b0;
            res_data_r      <= '0;
            res_tag_r       <= '0;
            res_dest_r      <= '0;
            res_is_jeq_r    <= 1'b0;
            res_jeq_taken_r <= 1'b0;
        end else if (issue_s) begin
            res_valid_r     <= 1'b1;
            res_data_r      <= res_data_n;
            res_tag_r       <= res_tag_n;
            res_dest_r      <= sel_s.dest;
            res_is_jeq_r    <= res_is_jeq_n;
            res_jeq_taken_r <= res_jeq_taken_n;
        end else if (res_ready) begin
            res_valid_r     <= 1'b0;
        end else begin
            res_valid_r     <= res_valid_r;
        end
    end

    assign alloc_ready   = have_free_s;
    assign alloc_tag     = alloc_tag_s;
    assign res_valid     = res_valid_r;
    assign res_data      = res_data_r;
    assign res_tag       = res_tag_r;
    assign res_dest      = res_dest_r;
    assign res_is_jeq    = res_is_jeq_r;
    assign res_jeq_taken = res_jeq_taken_r;
    assign occupancy     = occupancy_r;

endmodule
